mlp_sequencer: RTL
==================

# mlp_sequencer

Controller that sequences one inference of the drowsiness-detector MLP (10 inputs → 5 hidden → 3 outputs) over a single shared multiply-accumulate unit and a 65-entry weight memory. It walks the weight addresses, selects the matching operand, drives the MAC clear/enable strobes and the activation write-back, then pulses `done`. It sits between the top-level control and the hidden/output-layer datapath and replaces free-running address counting with a start/done handshake.

## Interface
- `N_IN`, 10, inputs per hidden neuron
- `N_HID`, 5, hidden neurons (also inputs per output neuron)
- `N_OUT`, 3, output neurons
- `AW`, 7, weight address width (must cover N_IN·N_HID + N_HID·N_OUT)

- `Clock`  in  1  single clock, rising edge
- `Rst`  in  1  asynchronous, active-low reset
- `start`  in  1  request one inference; sampled only in IDLE
- `abort`  in  1  synchronous cancel of a running inference
- `busy`  out  1  high while an inference is in progress
- `done`  out  1  one-cycle completion pulse
- `w_re`  out  1  weight-memory read enable
- `w_addr`  out  AW  weight address (read data returns next cycle)
- `mac_en`  out  1  accumulate weight×operand this cycle
- `mac_clr`  out  1  with `mac_en`: load the product instead of adding it (first term of a neuron)
- `mac_layer`  out  1  operand source for `mac_en` cycle: 0 = external inputs, 1 = hidden activations
- `x_sel`  out  4  operand index for `mac_en` cycle
- `act_we`  out  1  accumulator holds a final neuron sum; write activated value
- `act_layer`  out  1  layer of `act_we` write: 0 hidden, 1 output
- `act_idx`  out  3  neuron index of `act_we` write
- `count`  out  10  busy-cycle counter of the current/last run

## Operation
- Reset: all outputs 0, state IDLE.
- States: IDLE → LOAD_H → DRAIN_H → LOAD_O → DRAIN_O → DONE → IDLE.
- IDLE: `start`=1 → LOAD_H; `count` cleared to 0.
- LOAD_H: one read per cycle, neuron j, input i: `w_addr` = j·N_IN + i, i fastest; H = N_IN·N_HID reads (addr 0..49), then DRAIN_H.
- DRAIN_H: 2 cycles, no reads; guarantees last hidden write lands before any output-layer operand use.
- LOAD_O: neuron k, hidden h: `w_addr` = H + k·N_HID + h; O = N_HID·N_OUT reads (addr 50..64), then DRAIN_O.
- DRAIN_O: 2 cycles, then DONE (1 cycle, `done`=1, `busy`=0), then IDLE.
- Pipeline stage 1 (one cycle after each read): `mac_en`=1, `x_sel`=i or h, `mac_layer`; `mac_clr`=1 when i/h = 0.
- Stage 2 (one cycle after the last term of a neuron): `act_we`=1 with `act_idx`, `act_layer`. May coincide with `mac_clr` of the next neuron; the datapath captures the old sum and clears on the same edge.
- `busy`=1 in LOAD_H through DRAIN_O. `count` increments on each edge with `busy`=1, holds otherwise; 10-bit wrap not reachable with defaults.
- `start` outside IDLE ignored (no queuing).
- `abort` while busy: next cycle IDLE, all strobes 0, no `done`, `count` holds. `abort` in IDLE/DONE ignored; `abort` wins over `start`.
- `Rst` low at any time: immediate return to reset values; in-flight pipeline strobes dropped.

## Timing
- Cycle 0 = IDLE cycle in which `start` is sampled.
- Defaults: `w_re` cycles 1–50 (addr 0–49), DRAIN_H 51–52, `w_re` 53–67 (addr 50–64), DRAIN_O 68–69, `done` cycle 70.
- `mac_en` 2–51 and 54–68; `mac_clr` 2,12,22,32,42 and 54,59,64.
- `act_we` hidden 12,22,32,42,52 (idx 0–4); output 59,64,69 (idx 0–2).
- General: `done` at cycle H+O+5; `count` = H+O+4 (69) after completion.
- Back-to-back: earliest next `start` sampled cycle 71, first read cycle 72.

## Test plan
- Reset: `Rst`=0 → every output 0, `count`=0; release, no `start` → outputs stay 0 for 100 cycles.
- Single run, start pulse cycle 0 → `w_addr` 0..49 on cycles 1–50, 50..64 on 53–67, `done`=1 only cycle 70, `count`=69.
- Strobe alignment → `mac_clr`/`act_we`/`act_idx`/`act_layer`/`x_sel` exactly on the cycles listed in Timing; `x_sel` 0–9 per hidden neuron, 0–4 per output neuron.
- `start` held high → `start` during run ignored; runs repeat with first `w_re` at cycles 1, 72, 143.
- `abort` cycle 30 → cycle 31 IDLE, no `done`, `count`=30 held; new `start` gives full 70-cycle run.
- `Rst` low cycle 40 (asynchronous, mid-cycle) → outputs 0 before next edge; after release, `start` gives nominal run.

Source files
------------

// File: rtl/mlp_sequencer.sv
// ---------------------------------------------------------------------------
// mlp_sequencer
//   Sequences one inference of the 10-5-3 drowsiness-detector MLP over a
//   single shared MAC and a 65-entry weight memory. The block walks the weight
//   addresses and drives the MAC strobes (one cycle after each read) and the
//   activation write-back (one cycle after the last term of a neuron).
//   Completion is signalled with a one-cycle done pulse.
//
// Handshake: start is a level request that is sampled only in IDLE. A start
//   seen in any other state is dropped, not queued. abort cancels a running
//   inference on the next edge; it is ignored when the block is not busy.
//   done is high for exactly one cycle, and busy is low during that cycle.
//
// Ports
//   Clock, Rst          clock (rising edge), asynchronous active-low reset
//   start, abort        run request / synchronous cancel
//   busy, done          run in progress / one-cycle completion pulse
//   w_re, w_addr        weight read strobe and address (data returns +1 cycle)
//   mac_en, mac_clr     accumulate / load-first-term strobes
//   mac_layer, x_sel    operand source (0 inputs, 1 hidden) and operand index
//   act_we, act_layer,  activation write strobe, layer (0 hidden, 1 output)
//   act_idx             and neuron index
//   count               busy-cycle counter of the current/last run
//   dbg_state           current FSM state
// ---------------------------------------------------------------------------
module mlp_sequencer #(
  parameter int N_IN  = 10,
  parameter int N_HID = 5,
  parameter int N_OUT = 3,
  parameter int AW    = 7
) (
  input  logic          Clock,
  input  logic          Rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          w_re,
  output logic [AW-1:0] w_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          mac_layer,
  output logic [3:0]    x_sel,
  output logic          act_we,
  output logic          act_layer,
  output logic [2:0]    act_idx,
  output logic [9:0]    count,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_H  = 3'd1,
    S_DRAIN_H = 3'd2,
    S_LOAD_O  = 3'd3,
    S_DRAIN_O = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [3:0] H_LAST_TERM = 4'(N_IN - 1);
  localparam logic [3:0] O_LAST_TERM = 4'(N_HID - 1);
  localparam logic [2:0] H_LAST_NRN  = 3'(N_HID - 1);
  localparam logic [2:0] O_LAST_NRN  = 3'(N_OUT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    term_q, term_d;
  logic [2:0]    nrn_q, nrn_d;
  logic          drn_q, drn_d;
  logic [9:0]    count_q, count_d;

  // Stage 1: operand strobes for the word read in the previous cycle.
  logic          s1_en_q, s1_en_d;
  logic          s1_clr_q, s1_clr_d;
  logic          s1_layer_q, s1_layer_d;
  logic [3:0]    s1_sel_q, s1_sel_d;
  logic          s1_last_q, s1_last_d;
  logic [2:0]    s1_nrn_q, s1_nrn_d;
  // Stage 2: activation write-back once the accumulator holds a full sum.
  logic          s2_we_q, s2_we_d;
  logic          s2_layer_q, s2_layer_d;
  logic [2:0]    s2_idx_q, s2_idx_d;

  logic rd, busy_c, last_term, last_nrn, kill;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    term_d  = term_q;
    nrn_d   = nrn_q;
    drn_d   = drn_q;
    count_d = count_q;

    rd        = (state_q == S_LOAD_H) || (state_q == S_LOAD_O);
    busy_c    = (state_q == S_LOAD_H) || (state_q == S_DRAIN_H) ||
                (state_q == S_LOAD_O) || (state_q == S_DRAIN_O);
    last_term = ((state_q == S_LOAD_H) && (term_q == H_LAST_TERM)) ||
                ((state_q == S_LOAD_O) && (term_q == O_LAST_TERM));
    last_nrn  = ((state_q == S_LOAD_H) && (nrn_q == H_LAST_NRN)) ||
                ((state_q == S_LOAD_O) && (nrn_q == O_LAST_NRN));
    kill      = abort && busy_c;

    if (busy_c) count_d = count_q + 10'd1;

    // Weights are stored layer-major, neuron-major, term fastest, so a
    // plain incrementing address matches the (neuron, term) walk.
    if (rd) begin
      addr_d = addr_q + AW'(1);
      if (last_term) begin
        term_d = 4'd0;
        nrn_d  = last_nrn ? 3'd0 : nrn_q + 3'd1;
      end else begin
        term_d = term_q + 4'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_H;
          count_d = 10'd0;
          addr_d  = '0;
          term_d  = 4'd0;
          nrn_d   = 3'd0;
        end
      end
      S_LOAD_H:  if (last_term && last_nrn) state_d = S_DRAIN_H;
      // Two idle cycles let the last hidden write land before its use.
      S_DRAIN_H: begin
        drn_d = ~drn_q;
        if (drn_q) state_d = S_LOAD_O;
      end
      S_LOAD_O:  if (last_term && last_nrn) state_d = S_DRAIN_O;
      S_DRAIN_O: begin
        drn_d = ~drn_q;
        if (drn_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (kill) begin
      state_d = S_IDLE;
      addr_d  = '0;
      term_d  = 4'd0;
      nrn_d   = 3'd0;
      drn_d   = 1'b0;
    end

    s1_en_d    = rd && !kill;
    s1_clr_d   = (term_q == 4'd0);
    s1_layer_d = (state_q == S_LOAD_O);
    s1_sel_d   = term_q;
    s1_last_d  = last_term;
    s1_nrn_d   = nrn_q;

    s2_we_d    = s1_en_q && s1_last_q && !kill;
    s2_layer_d = s1_layer_q;
    s2_idx_d   = s1_nrn_q;
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      term_q     <= 4'd0;
      nrn_q      <= 3'd0;
      drn_q      <= 1'b0;
      count_q    <= 10'd0;
      s1_en_q    <= 1'b0;
      s1_clr_q   <= 1'b0;
      s1_layer_q <= 1'b0;
      s1_sel_q   <= 4'd0;
      s1_last_q  <= 1'b0;
      s1_nrn_q   <= 3'd0;
      s2_we_q    <= 1'b0;
      s2_layer_q <= 1'b0;
      s2_idx_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      term_q     <= term_d;
      nrn_q      <= nrn_d;
      drn_q      <= drn_d;
      count_q    <= count_d;
      s1_en_q    <= s1_en_d;
      s1_clr_q   <= s1_clr_d;
      s1_layer_q <= s1_layer_d;
      s1_sel_q   <= s1_sel_d;
      s1_last_q  <= s1_last_d;
      s1_nrn_q   <= s1_nrn_d;
      s2_we_q    <= s2_we_d;
      s2_layer_q <= s2_layer_d;
      s2_idx_q   <= s2_idx_d;
    end
  end

  // Side-band fields are forced to 0 outside their strobe so idle outputs
  // are clean zeros.
  assign busy      = (state_q == S_LOAD_H) || (state_q == S_DRAIN_H) ||
                     (state_q == S_LOAD_O) || (state_q == S_DRAIN_O);
  assign done      = (state_q == S_DONE);
  assign w_re      = (state_q == S_LOAD_H) || (state_q == S_LOAD_O);
  assign w_addr    = w_re ? addr_q : '0;
  assign mac_en    = s1_en_q;
  assign mac_clr   = s1_en_q && s1_clr_q;
  assign mac_layer = s1_en_q && s1_layer_q;
  assign x_sel     = s1_en_q ? s1_sel_q : 4'd0;
  assign act_we    = s2_we_q;
  assign act_layer = s2_we_q && s2_layer_q;
  assign act_idx   = s2_we_q ? s2_idx_q : 3'd0;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule
